// File: rtl/servive_gpio_uart.sv
// servive_gpio_uart: watches the 8-bit GPIO output of a servant core and
// sends every change of value over an 8N1 UART line. Changes are queued in
// a small FIFO so short bursts are not lost; when the FIFO is full, a
// change is dropped and a sticky overflow flag is raised until reset.
module servive_gpio_uart #(
  parameter int CLKS_PER_BIT = 434,  // i_clk cycles per UART bit, >= 2
  parameter int FIFO_DEPTH   = 4     // pending bytes, power of two >= 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_q,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Change detector and FIFO bookkeeping. The pointers carry one extra
  // wrap bit so full and empty can be told apart without a counter.
  logic [7:0]  q_last_q, q_last_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic        push_req;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_head;

  // Transmitter state.
  state_e         state_q;
  logic [BW-1:0]  baud_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           tx_q;

  // Next-state logic for the change detector and the FIFO pointers.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first,
    // otherwise synthesis would infer a latch to hold the old value.
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    fifo_head  = fifo_mem[rd_ptr_q[PW-1:0]];

    // The FSM only sees registered FIFO state, so a byte written into an
    // empty FIFO is popped one edge later, never in the same edge.
    pop        = (state_q == IDLE) && !fifo_empty;

    push_req   = (i_q != q_last_q);
    // A full FIFO can still take a byte when the head leaves in the same edge.
    push       = push_req && (!fifo_full || pop);

    // The last-seen value follows i_q even when the byte is dropped, so a
    // dropped change is not retried.
    q_last_d   = push_req ? i_q : q_last_q;
    wr_ptr_d   = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
    overflow_d = overflow_q || (push_req && !push);
  end

  // Change detector and FIFO pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: clocked state always uses non-blocking assignments so every
      // register samples the values from before the edge, whatever the
      // order the blocks are evaluated in.
      q_last_q   <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      q_last_q   <= q_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array is deliberately left out of reset; the
    // pointers alone decide which entries are valid, and an unreset array
    // maps onto plain RAM or cheaper flops.
    if (push) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= i_q;
    end
  end

  // UART transmit FSM: start bit, 8 data bits LSB first, stop bit.
  // The baud counter restarts at 0 on every state or bit change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= 3'd0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= fifo_head;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end

        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= 3'd0;
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          bit_q   <= 3'd0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Outputs are registers or a decode of registers only.
  assign o_tx       = tx_q;
  assign o_busy     = (state_q != IDLE) || !fifo_empty;
  assign o_overflow = overflow_q;

endmodule
